// File: rtl/column_offset_calibrator.sv
// Column dark-level calibrator: averages 2^LINES_LOG2 lines per column after a
// frame boundary and writes unity-gain, saturated offsets into the correction LUT.
module column_offset_calibrator #(
    parameter int DATA_BITS      = 32,
    parameter int PIXEL_BITS     = 8,
    parameter int N              = DATA_BITS / PIXEL_BITS,
    parameter int GAIN_BITS      = 8,
    parameter int GAIN_FRAC_BITS = 7,
    parameter int OFFSET_BITS    = 8,
    parameter int WIDTH_BITS     = 10,
    parameter int LINES_LOG2     = 4,
    parameter int TARGET         = 16,
    parameter int LUT_DATA_BITS  = (GAIN_BITS + OFFSET_BITS) * N,
    parameter int ACC_BITS       = PIXEL_BITS + LINES_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_BITS-1:0]     data_i,
    input  logic                     valid_i,
    input  logic                     eol_i,
    input  logic                     eof_i,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WIDTH_BITS-1:0]    lut_waddr,
    output logic [LUT_DATA_BITS-1:0] lut_wdata,
    output logic                     lut_we
);
    localparam int LW = GAIN_BITS + OFFSET_BITS;
    localparam logic signed [PIXEL_BITS+1:0] TARGET_W = (PIXEL_BITS+2)'(TARGET);
    localparam logic signed [PIXEL_BITS+1:0] OFF_MAX  = (PIXEL_BITS+2)'((1 << (OFFSET_BITS-1)) - 1);
    localparam logic signed [PIXEL_BITS+1:0] OFF_MIN  = (PIXEL_BITS+2)'(-(1 << (OFFSET_BITS-1)));
    localparam logic [GAIN_BITS-1:0]         GAIN_ONE = GAIN_BITS'(1 << GAIN_FRAC_BITS);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ACCUM, S_WRITE, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [WIDTH_BITS-1:0]    col_q, col_d, wcnt_q, wcnt_d;
    logic [WIDTH_BITS:0]      col_count_q, col_count_d;
    logic [LINES_LOG2-1:0]    line_q, line_d;
    logic                     err_q, err_d, busy_q, busy_d, done_q, done_d, issue_q, issue_d;
    logic                     rmw_v_q, rmw_v_d, rmw_first_q, rmw_first_d;
    logic [WIDTH_BITS-1:0]    rmw_addr_q, rmw_addr_d;
    logic [DATA_BITS-1:0]     rmw_pix_q, rmw_pix_d;
    logic                     s1_v_q, s1_v_d;
    logic [WIDTH_BITS-1:0]    s1_addr_q, s1_addr_d;
    logic                     lut_we_q, lut_we_d;
    logic [WIDTH_BITS-1:0]    lut_waddr_q, lut_waddr_d;
    logic [LUT_DATA_BITS-1:0] lut_wdata_q, lut_wdata_d, lut_word_s;
    logic [WIDTH_BITS-1:0]    rd_addr_s;
    logic [N*ACC_BITS-1:0]    rd_data_q, ram_wdata_s;
    logic [N*ACC_BITS-1:0]    acc_ram [2**WIDTH_BITS];
    logic                     first_line_s, in_range_s, last_line_s, last_issue_s, last_out_s;

    // Mean, signed difference to the target, then clamp into the offset field.
    function automatic logic [LW-1:0] lane_word(input logic [ACC_BITS-1:0] acc);
        logic [PIXEL_BITS-1:0]        mean;
        logic signed [PIXEL_BITS+1:0] diff;
        logic [OFFSET_BITS-1:0]       off;
        mean = acc[ACC_BITS-1:LINES_LOG2];
        diff = TARGET_W - $signed({2'b00, mean});
        if (diff > OFF_MAX) begin
            off = OFF_MAX[OFFSET_BITS-1:0];
        end else if (diff < OFF_MIN) begin
            off = OFF_MIN[OFFSET_BITS-1:0];
        end else begin
            off = diff[OFFSET_BITS-1:0];
        end
        return {off, GAIN_ONE};
    endfunction

    assign first_line_s = (line_q == LINES_LOG2'(0));
    assign last_line_s  = (line_q == {LINES_LOG2{1'b1}});
    assign in_range_s   = first_line_s || ({1'b0, col_q} < col_count_q);
    assign last_issue_s = ({1'b0, wcnt_q} == col_count_q - (WIDTH_BITS+1)'(1));
    assign last_out_s   = ({1'b0, lut_waddr_q} == col_count_q - (WIDTH_BITS+1)'(1));
    assign rd_addr_s    = (state_q == S_WRITE) ? wcnt_q : col_q;

    // Accumulator RAM: registered read, write from the RMW pipeline stage.
    always_ff @(posedge clk) begin
        rd_data_q <= acc_ram[rd_addr_s];
        if (rmw_v_q) begin
            acc_ram[rmw_addr_q] <= ram_wdata_s;
        end
    end

    // Per-lane accumulate (first line stores raw pixels) and LUT word assembly.
    always_comb begin
        ram_wdata_s = '0;
        lut_word_s  = '0;
        for (int i = 0; i < N; i++) begin
            ram_wdata_s[ACC_BITS*i +: ACC_BITS] =
                (rmw_first_q ? ACC_BITS'(0) : rd_data_q[ACC_BITS*i +: ACC_BITS])
                + ACC_BITS'(rmw_pix_q[PIXEL_BITS*i +: PIXEL_BITS]);
            lut_word_s[LW*i +: LW] = lane_word(rd_data_q[ACC_BITS*i +: ACC_BITS]);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            wcnt_q      <= '0;
            col_count_q <= '0;
            line_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            issue_q     <= 1'b0;
            rmw_v_q     <= 1'b0;
            rmw_first_q <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_pix_q   <= '0;
            s1_v_q      <= 1'b0;
            s1_addr_q   <= '0;
            lut_we_q    <= 1'b0;
            lut_waddr_q <= '0;
            lut_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            wcnt_q      <= wcnt_d;
            col_count_q <= col_count_d;
            line_q      <= line_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            issue_q     <= issue_d;
            rmw_v_q     <= rmw_v_d;
            rmw_first_q <= rmw_first_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_pix_q   <= rmw_pix_d;
            s1_v_q      <= s1_v_d;
            s1_addr_q   <= s1_addr_d;
            lut_we_q    <= lut_we_d;
            lut_waddr_q <= lut_waddr_d;
            lut_wdata_q <= lut_wdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SYNC; else state_d = S_IDLE;
            S_SYNC:  if (valid_i && eof_i) state_d = S_ACCUM; else state_d = S_SYNC;
            S_ACCUM: if (valid_i && eol_i && last_line_s) state_d = S_WRITE; else state_d = S_ACCUM;
            S_WRITE: if (lut_we_q && last_out_s) state_d = S_DONE; else state_d = S_WRITE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic; busy/done derive from the next state so they are registered.
    always_comb begin
        col_d       = col_q;
        wcnt_d      = wcnt_q;
        col_count_d = col_count_q;
        line_d      = line_q;
        err_d       = err_q;
        issue_d     = issue_q;
        rmw_v_d     = 1'b0;
        rmw_first_d = rmw_first_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_pix_d   = rmw_pix_q;
        s1_v_d      = 1'b0;
        s1_addr_d   = s1_addr_q;
        busy_d      = (state_d == S_SYNC) || (state_d == S_ACCUM) || (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);
        lut_we_d    = s1_v_q;
        lut_waddr_d = s1_v_q ? s1_addr_q : lut_waddr_q;
        lut_wdata_d = s1_v_q ? lut_word_s : lut_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d  = 1'b0;
                    line_d = '0;
                    col_d  = '0;
                end else begin
                    err_d = err_q;
                end
            end
            S_ACCUM: begin
                if (valid_i) begin
                    rmw_v_d     = in_range_s;
                    rmw_first_d = first_line_s;
                    rmw_addr_d  = col_q;
                    rmw_pix_d   = data_i;
                    if (!in_range_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (eol_i) begin
                        col_d  = '0;
                        line_d = line_q + LINES_LOG2'(1);
                        if (first_line_s) begin
                            col_count_d = {1'b0, col_q} + (WIDTH_BITS+1)'(1);
                        end else if (({1'b0, col_q} + (WIDTH_BITS+1)'(1)) < col_count_q) begin
                            err_d = 1'b1;
                        end else begin
                            col_count_d = col_count_q;
                        end
                        if (last_line_s) begin
                            wcnt_d  = '0;
                            issue_d = 1'b1;
                        end else begin
                            issue_d = issue_q;
                        end
                    end else begin
                        col_d = col_q + WIDTH_BITS'(1);
                    end
                end else begin
                    col_d = col_q;
                end
            end
            S_WRITE: begin
                if (issue_q) begin
                    s1_v_d    = 1'b1;
                    s1_addr_d = wcnt_q;
                    if (last_issue_s) begin
                        issue_d = 1'b0;
                    end else begin
                        wcnt_d = wcnt_q + WIDTH_BITS'(1);
                    end
                end else begin
                    issue_d = 1'b0;
                end
            end
            default: begin
                issue_d = issue_q;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign lut_we    = lut_we_q;
    assign lut_waddr = lut_waddr_q;
    assign lut_wdata = lut_wdata_q;
endmodule

// File: tb/tb_column_offset_calibrator.sv
// Scoreboard bench for column_offset_calibrator: expected LUT words are queued
// from a reference model as each calibration is driven and popped on lut_we.
module tb_column_offset_calibrator;
    localparam int LL = 2;

    logic        clk = 1'b0;
    logic        rst, start, valid_i, eol_i, eof_i;
    logic [31:0] data_i;
    logic        busy, done, err, lut_we;
    logic [9:0]  lut_waddr;
    logic [63:0] lut_wdata;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [9:0]  exp_addr_q[$];
    logic [63:0] exp_data_q[$];

    column_offset_calibrator #(.LINES_LOG2(LL)) dut (
        .clk(clk), .rst(rst), .start(start), .data_i(data_i), .valid_i(valid_i),
        .eol_i(eol_i), .eof_i(eof_i), .busy(busy), .done(done), .err(err),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .lut_we(lut_we)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Pops one expected word per LUT write; a write with nothing queued is an error.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (lut_we === 1'b1) begin
            check_eq("we_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) begin
                check_eq("lut_waddr", {54'd0, lut_waddr}, {54'd0, exp_addr_q.pop_front()});
                check_eq("lut_wdata", lut_wdata, exp_data_q.pop_front());
            end
        end
    end

    function automatic logic [7:0] pix(input int mode, input int uval, input int l, input int c, input int i);
        case (mode)
            1:       return 8'(4 * c + i);
            2:       return (l % 2 == 1) ? 8'd11 : 8'd10;
            default: return 8'(uval);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic e, input logic f, input logic s);
        repeat ($urandom_range(0, 1)) tick();
        data_i  = d;
        valid_i = 1'b1;
        eol_i   = e;
        eof_i   = f;
        start   = s;
        tick();
        valid_i = 1'b0;
        eol_i   = 1'b0;
        eof_i   = 1'b0;
        start   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic sync_frame();
        drive_beat(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        drive_beat(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic run_cal(input string name, input int mode, input int uval,
                           input int l0, input int l1, input int l2, input int l3,
                           input int eof_line, input int start_line, input logic exp_err);
        int          lens[4];
        logic [63:0] word;
        logic [31:0] d;
        int          sum, dd;
        lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
        for (int c = 0; c < lens[0]; c++) begin
            word = '0;
            for (int i = 0; i < 4; i++) begin
                sum = 0;
                for (int l = 0; l < 4; l++)
                    if (c < lens[l]) sum += int'(pix(mode, uval, l, c, i));
                dd = 16 - (sum >> LL);
                if (dd > 127) dd = 127;
                if (dd < -128) dd = -128;
                word[16*i +: 16] = {8'(dd), 8'h80};
            end
            exp_addr_q.push_back(10'(c));
            exp_data_q.push_back(word);
        end
        done_cnt = 0;
        pulse_start();
        sync_frame();
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < lens[l]; c++) begin
                for (int i = 0; i < 4; i++) d[8*i +: 8] = pix(mode, uval, l, c, i);
                drive_beat(d, c == lens[l] - 1, (l == eof_line) && (c == lens[l] - 1),
                           (l == start_line) && (c == 0));
            end
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check_eq({name, "_busy_at_done"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check_eq({name, "_done_once"}, 64'(done_cnt), 64'd1);
        check_eq({name, "_queue_drained"}, 64'(exp_addr_q.size()), 64'd0);
        check_eq({name, "_err"}, 64'(err), 64'(exp_err));
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid_i = 1'b0; eol_i = 1'b0; eof_i = 1'b0; data_i = '0;
        repeat (3) tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_we", 64'(lut_we), 64'd0);
        check_eq("rst_waddr", {54'd0, lut_waddr}, 64'd0);
        check_eq("rst_wdata", lut_wdata, 64'd0);
        rst = 1'b0;
        tick();

        run_cal("uniform", 0, 10, 4, 4, 4, 4, -1, -1, 1'b0);
        run_cal("sat_hi", 0, 200, 4, 4, 4, 4, -1, -1, 1'b0);
        run_cal("sat_zero", 0, 0, 4, 4, 4, 4, -1, -1, 1'b0);
        run_cal("ramp", 1, 0, 4, 4, 4, 4, -1, -1, 1'b0);
        run_cal("trunc", 2, 0, 4, 4, 4, 4, -1, -1, 1'b0);
        run_cal("span", 0, 10, 4, 4, 4, 4, 1, -1, 1'b0);
        run_cal("long", 0, 10, 4, 5, 4, 4, -1, 2, 1'b1);
        run_cal("short", 0, 10, 4, 4, 3, 4, -1, -1, 1'b1);

        // Abort mid-accumulation, then confirm a clean restart.
        pulse_start();
        sync_frame();
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 4; c++)
                drive_beat(32'h0A0A_0A0A, c == 3, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_we", 64'(lut_we), 64'd0);
        rst = 1'b0;
        repeat (20) tick();
        run_cal("after_rst", 0, 10, 4, 4, 4, 4, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
